// File: rtl/ddr_req_arbiter.sv
// ddr_req_arbiter: shares the single DDR port between instruction fetch (IF)
// and load/store (LS). One transaction is in flight at a time. LS has
// priority, and a saturating starvation counter hands the port to a waiting
// IF after STARVE_LIMIT consecutive LS grants.
module ddr_req_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         if_req_valid,
    output logic         if_req_ready,
    input  logic [63:0]  if_req_addr,
    input  logic         if_flush,
    output logic         if_resp_valid,
    output logic [127:0] if_resp_data,
    input  logic         ls_req_valid,
    output logic         ls_req_ready,
    input  logic [63:0]  ls_req_addr,
    input  logic         ls_req_we,
    input  logic [63:0]  ls_req_wdata,
    input  logic [7:0]   ls_req_wmask,
    output logic         ls_resp_valid,
    output logic [63:0]  ls_resp_data,
    output logic         mem_req_valid,
    input  logic         mem_req_ready,
    output logic [63:0]  mem_req_addr,
    output logic         mem_req_we,
    output logic [127:0] mem_req_wdata,
    output logic [15:0]  mem_req_wmask,
    input  logic         mem_resp_valid,
    input  logic [127:0] mem_resp_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    state_t     state;
    logic       owner_ls;   // 0 = IF owns the transaction, 1 = LS
    logic       drop;       // IF response of the current transaction is discarded
    logic [2:0] starve_cnt;
    logic       in_idle;
    logic       if_ok;
    logic       starve_hit;
    logic       grant_if;
    logic       grant_ls;

    // Saturating 3-bit increment for the starvation counter.
    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    // An 8-byte LS mask lands in the 16-byte beat half selected by addr[3].
    function automatic logic [15:0] place_mask(input logic [7:0] m, input logic hi);
        return hi ? {m, 8'h00} : {8'h00, m};
    endfunction

    // LS read data is the beat half selected by addr[3]; writes return zero.
    function automatic logic [63:0] pick_half(input logic [127:0] d, input logic hi,
                                              input logic we);
        if (we) begin
            return 64'h0;
        end
        return hi ? d[127:64] : d[63:0];
    endfunction

    // Grant decision: only in IDLE, LS first unless IF has been starved; a
    // flushing IF request is never granted.
    always_comb begin
        in_idle    = reset_n && (state == ST_IDLE);
        if_ok      = if_req_valid && !if_flush;
        starve_hit = if_req_valid && (starve_cnt == LIMIT);
        grant_if   = in_idle && if_ok && (!ls_req_valid || starve_hit);
        grant_ls   = in_idle && ls_req_valid && !grant_if;
    end

    assign if_req_ready  = grant_if;
    assign ls_req_ready  = grant_ls;
    assign ls_resp_valid = (state == ST_RESP) && owner_ls;
    // A flush arriving in the response cycle itself still suppresses the pulse.
    assign if_resp_valid = (state == ST_RESP) && !owner_ls && !drop && !if_flush;

    // Transaction FSM with latched request fields, captured response data,
    // drop flag and starvation counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            owner_ls      <= 1'b0;
            drop          <= 1'b0;
            starve_cnt    <= 3'd0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= 64'h0;
            mem_req_we    <= 1'b0;
            mem_req_wdata <= 128'h0;
            mem_req_wmask <= 16'h0;
            if_resp_data  <= 128'h0;
            ls_resp_data  <= 64'h0;
        end else begin
            if (grant_if || !if_req_valid) begin
                starve_cnt <= 3'd0;
            end else if (grant_ls) begin
                starve_cnt <= sat_inc3(starve_cnt);
            end

            case (state)
                ST_IDLE: begin
                    if (grant_if) begin
                        state         <= ST_REQ;
                        owner_ls      <= 1'b0;
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= if_req_addr;
                        mem_req_we    <= 1'b0;
                        mem_req_wdata <= 128'h0;
                        mem_req_wmask <= 16'h0;
                    end else if (grant_ls) begin
                        state         <= ST_REQ;
                        owner_ls      <= 1'b1;
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= ls_req_addr;
                        mem_req_we    <= ls_req_we;
                        mem_req_wdata <= {ls_req_wdata, ls_req_wdata};
                        mem_req_wmask <= place_mask(ls_req_wmask, ls_req_addr[3]);
                    end
                end
                ST_REQ: begin
                    if (!owner_ls && if_flush) begin
                        drop <= 1'b1;
                    end
                    if (mem_req_ready) begin
                        state         <= ST_WAIT;
                        mem_req_valid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (!owner_ls && if_flush) begin
                        drop <= 1'b1;
                    end
                    if (mem_resp_valid) begin
                        state <= ST_RESP;
                        if (owner_ls) begin
                            ls_resp_data <= pick_half(mem_resp_data, mem_req_addr[3], mem_req_we);
                        end else begin
                            if_resp_data <= mem_resp_data;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    drop  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// tb_ddr_req_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level reference model of the arbiter.
module tb_ddr_req_arbiter;

    localparam int LIMIT = 4;
    localparam int OW    = 404;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         if_req_valid = 1'b0;
    logic         if_req_ready;
    logic [63:0]  if_req_addr = 64'h0;
    logic         if_flush = 1'b0;
    logic         if_resp_valid;
    logic [127:0] if_resp_data;
    logic         ls_req_valid = 1'b0;
    logic         ls_req_ready;
    logic [63:0]  ls_req_addr = 64'h0;
    logic         ls_req_we = 1'b0;
    logic [63:0]  ls_req_wdata = 64'h0;
    logic [7:0]   ls_req_wmask = 8'h0;
    logic         ls_resp_valid;
    logic [63:0]  ls_resp_data;
    logic         mem_req_valid;
    logic         mem_req_ready = 1'b0;
    logic [63:0]  mem_req_addr;
    logic         mem_req_we;
    logic [127:0] mem_req_wdata;
    logic [15:0]  mem_req_wmask;
    logic         mem_resp_valid = 1'b0;
    logic [127:0] mem_resp_data = 128'h0;

    int n_pass  = 0;
    int n_total = 0;

    // DDR responder model state
    int unsigned  rdy_pct    = 100;
    int unsigned  junk_pct   = 0;
    int           stall_left = 0;
    int           resp_lat   = 1;
    int           resp_cd    = 0;
    int           ddr_done   = 0;
    bit           resp_pend  = 1'b0;
    bit           ovr_en     = 1'b0;
    logic [127:0] ovr_data   = 128'h0;
    logic [63:0]  resp_addr  = 64'h0;

    ddr_req_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_req_addr   (if_req_addr),
        .if_flush      (if_flush),
        .if_resp_valid (if_resp_valid),
        .if_resp_data  (if_resp_data),
        .ls_req_valid  (ls_req_valid),
        .ls_req_ready  (ls_req_ready),
        .ls_req_addr   (ls_req_addr),
        .ls_req_we     (ls_req_we),
        .ls_req_wdata  (ls_req_wdata),
        .ls_req_wmask  (ls_req_wmask),
        .ls_resp_valid (ls_resp_valid),
        .ls_resp_data  (ls_resp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_we    (mem_req_we),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wmask (mem_req_wmask),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data)
    );

    always #5 clock = ~clock;

    function automatic logic [127:0] ddr_data(input logic [63:0] a);
        return ovr_en ? ovr_data : {a ^ 64'hA5A5_5A5A_0F0F_F0F0, ~a};
    endfunction

    function automatic logic [OW-1:0] all_out();
        return {mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wmask,
                if_resp_valid, if_resp_data, ls_resp_valid, ls_resp_data};
    endfunction

    task automatic idle_inputs();
        if_req_valid = 1'b0;
        if_flush     = 1'b0;
        ls_req_valid = 1'b0;
        ls_req_we    = 1'b0;
        ls_req_wdata = 64'h0;
        ls_req_wmask = 8'h0;
    endtask

    // Drive the DDR side for the current cycle from the responder model.
    task automatic ddr_drive();
        mem_req_ready = 1'b0;
        if (mem_req_valid) begin
            if (stall_left > 0) stall_left--;
            else mem_req_ready = ($urandom_range(99) < rdy_pct);
        end
        mem_resp_valid = 1'b0;
        mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
        if (resp_pend && resp_cd == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = ddr_data(resp_addr);
        end else if (!resp_pend && $urandom_range(99) < junk_pct) begin
            mem_resp_valid = 1'b1;
        end
    endtask

    // Record what the coming clock edge does on the DDR side.
    task automatic ddr_note();
        if (resp_pend) begin
            if (resp_cd == 0) begin
                resp_pend = 1'b0;
                ddr_done++;
            end else begin
                resp_cd--;
            end
        end
        if (mem_req_valid && mem_req_ready) begin
            resp_pend = 1'b1;
            resp_cd   = resp_lat - 1;
            resp_addr = mem_req_addr;
        end
    endtask

    task automatic settle();
        ddr_drive();
        #1;
    endtask

    task automatic advance();
        ddr_note();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        idle_inputs();
        repeat (14) begin
            settle();
            advance();
        end
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        idle_inputs();
        stall_left = 0;
        resp_pend  = 1'b0;
        junk_pct   = 0;
        repeat (2) begin
            settle();
            advance();
        end
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        if_req_valid = 1'b1;
        if_req_addr  = 64'h40;
        ls_req_valid = 1'b1;
        settle();
        n_total++;
        if ({if_req_ready, ls_req_ready} !== 2'b00)
            $display("FAIL reset_ready got=%b exp=00", {if_req_ready, ls_req_ready});
        else n_pass++;
        n_total++;
        if (all_out() !== '0) $display("FAIL reset_outputs got=%h exp=0", all_out());
        else n_pass++;
        advance();
        settle();
        n_total++;
        if (all_out() !== '0) $display("FAIL reset_outputs_held got=%h exp=0", all_out());
        else n_pass++;
        advance();
        reset_n      = 1'b1;
        ls_req_valid = 1'b0;
        settle();
        n_total++;
        if (if_req_ready !== 1'b1) $display("FAIL reset_first_grant got=%b exp=1", if_req_ready);
        else n_pass++;
        idle_inputs();
        settle();
        advance();
    endtask

    task automatic test_if_read();
        int got = -1;
        int pulses = 0;
        logic [127:0] gdata = '0;
        rdy_pct  = 100;
        resp_lat = 1;
        ovr_en   = 1'b1;
        ovr_data = {16{8'hA5}};
        if_req_valid = 1'b1;
        if_req_addr  = 64'h1000;
        settle();
        n_total++;
        if ({if_req_ready, ls_req_ready} !== 2'b10)
            $display("FAIL if_read_grant got=%b exp=10", {if_req_ready, ls_req_ready});
        else n_pass++;
        advance();
        if_req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            settle();
            if (c == 1) begin
                n_total++;
                if ({mem_req_valid, mem_req_addr, mem_req_we} !== {1'b1, 64'h1000, 1'b0})
                    $display("FAIL if_read_memreq got=%b/%h/%b exp=1/1000/0",
                             mem_req_valid, mem_req_addr, mem_req_we);
                else n_pass++;
            end
            if (if_resp_valid) begin
                pulses++;
                if (got < 0) begin
                    got   = c;
                    gdata = if_resp_data;
                end
            end
            advance();
        end
        n_total++;
        if (got != 3 || pulses != 1)
            $display("FAIL if_read_latency got=cycle%0d/pulses%0d exp=cycle3/pulses1", got, pulses);
        else n_pass++;
        n_total++;
        if (gdata !== {16{8'hA5}}) $display("FAIL if_read_data got=%h exp=%h", gdata, {16{8'hA5}});
        else n_pass++;
        ovr_en = 1'b0;
    endtask

    task automatic test_simultaneous();
        int ls_resp_cyc = -1;
        int if_g = -1;
        if_req_valid = 1'b1;
        if_req_addr  = 64'h6000;
        ls_req_valid = 1'b1;
        ls_req_addr  = 64'h5000;
        ls_req_we    = 1'b0;
        settle();
        n_total++;
        if ({if_req_ready, ls_req_ready} !== 2'b01)
            $display("FAIL simul_first_grant got=%b exp=01", {if_req_ready, ls_req_ready});
        else n_pass++;
        advance();
        ls_req_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (if_g > 0) if_req_valid = 1'b0;
            settle();
            if (ls_resp_valid && ls_resp_cyc < 0) ls_resp_cyc = c;
            if (if_req_ready && if_g < 0) if_g = c;
            advance();
        end
        n_total++;
        if (ls_resp_cyc != 3 || if_g != 4)
            $display("FAIL simul_order got=lsresp%0d/ifgrant%0d exp=lsresp3/ifgrant4", ls_resp_cyc, if_g);
        else n_pass++;
        drain();
    endtask

    task automatic test_starvation();
        logic [6:0] seq = '0;
        int ng = 0;
        int both = 0;
        rdy_pct  = 100;
        resp_lat = 1;
        if_req_valid = 1'b1;
        if_req_addr  = 64'h8000;
        ls_req_valid = 1'b1;
        ls_req_addr  = 64'h9000;
        for (int c = 0; c < 80 && ng < 7; c++) begin
            settle();
            if (if_req_ready && ls_req_ready) both++;
            if (if_req_ready || ls_req_ready) begin
                seq = {seq[5:0], if_req_ready};
                ng++;
            end
            advance();
        end
        n_total++;
        if (ng != 7 || seq !== 7'b0000100)
            $display("FAIL starve_order got=n%0d/%b exp=n7/0000100 (1=IF)", ng, seq);
        else n_pass++;
        n_total++;
        if (both != 0) $display("FAIL starve_one_ready got=%0d exp=0", both);
        else n_pass++;
        drain();
    endtask

    task automatic test_ls_write();
        int got = -1;
        logic [63:0] gdata = '1;
        ls_req_valid = 1'b1;
        ls_req_we    = 1'b1;
        ls_req_addr  = 64'h2008;
        ls_req_wmask = 8'h0F;
        ls_req_wdata = 64'h1122334455667788;
        settle();
        n_total++;
        if (ls_req_ready !== 1'b1) $display("FAIL ls_write_grant got=%b exp=1", ls_req_ready);
        else n_pass++;
        advance();
        idle_inputs();
        for (int c = 1; c <= 8; c++) begin
            settle();
            if (c == 1) begin
                n_total++;
                if ({mem_req_we, mem_req_addr, mem_req_wmask, mem_req_wdata} !==
                    {1'b1, 64'h2008, 16'h0F00, {2{64'h1122334455667788}}})
                    $display("FAIL ls_write_memreq got=%b/%h/%h/%h exp=1/2008/0f00/%h",
                             mem_req_we, mem_req_addr, mem_req_wmask, mem_req_wdata,
                             {2{64'h1122334455667788}});
                else n_pass++;
            end
            if (ls_resp_valid && got < 0) begin
                got   = c;
                gdata = ls_resp_data;
            end
            advance();
        end
        n_total++;
        if (got != 3 || gdata !== 64'h0)
            $display("FAIL ls_write_resp got=cycle%0d/%h exp=cycle3/0", got, gdata);
        else n_pass++;
    endtask

    task automatic test_flush_stall();
        int vcnt = 0;
        int unstable = 0;
        int pulses = 0;
        int done0 = ddr_done;
        rdy_pct    = 100;
        resp_lat   = 3;
        stall_left = 5;
        if_req_valid = 1'b1;
        if_req_addr  = 64'h3000;
        settle();
        advance();
        if_req_valid = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if_flush = (c == 8);
            settle();
            if (mem_req_valid) begin
                vcnt++;
                if (mem_req_addr !== 64'h3000) unstable++;
            end
            if (if_resp_valid) pulses++;
            advance();
        end
        if_flush = 1'b0;
        n_total++;
        if (vcnt != 6 || unstable != 0)
            $display("FAIL stall_hold got=valid%0d/unstable%0d exp=valid6/unstable0", vcnt, unstable);
        else n_pass++;
        n_total++;
        if (pulses != 0) $display("FAIL flush_suppress got=%0d exp=0", pulses);
        else n_pass++;
        n_total++;
        if (ddr_done - done0 != 1) $display("FAIL flush_ddr_done got=%0d exp=1", ddr_done - done0);
        else n_pass++;
        resp_lat     = 1;
        pulses       = 0;
        if_req_valid = 1'b1;
        if_req_addr  = 64'h3010;
        settle();
        n_total++;
        if (if_req_ready !== 1'b1) $display("FAIL flush_regrant got=%b exp=1", if_req_ready);
        else n_pass++;
        advance();
        if_req_valid = 1'b0;
        repeat (6) begin
            settle();
            if (if_resp_valid) pulses++;
            advance();
        end
        n_total++;
        if (pulses != 1) $display("FAIL flush_cleared got=%0d exp=1", pulses);
        else n_pass++;
    endtask

    task automatic test_reset_wait();
        int pulses = 0;
        int mv = 0;
        rdy_pct  = 100;
        resp_lat = 4;
        if_req_valid = 1'b1;
        if_req_addr  = 64'h7000;
        settle();
        advance();
        if_req_valid = 1'b0;
        settle();
        advance();
        settle();
        advance();
        reset_n = 1'b0;
        settle();
        n_total++;
        if ({if_req_ready, ls_req_ready, all_out()} !== '0)
            $display("FAIL reset_wait_outputs got=%h exp=0", all_out());
        else n_pass++;
        advance();
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            settle();
            if (if_resp_valid || ls_resp_valid) pulses++;
            if (mem_req_valid) mv++;
            if (c == 0) begin
                n_total++;
                if (all_out() !== '0) $display("FAIL reset_wait_after got=%h exp=0", all_out());
                else n_pass++;
            end
            advance();
        end
        n_total++;
        if (pulses != 0 || mv != 0)
            $display("FAIL reset_wait_noresp got=pulses%0d/memvalid%0d exp=0/0", pulses, mv);
        else n_pass++;
    endtask

    task automatic test_random();
        int           m_phase = 0;   // 0 free, 1 issuing, 2 awaiting DDR, 3 responding
        int           m_starve = 0;
        bit           m_ls = 1'b0;
        bit           m_drop = 1'b0;
        logic [63:0]  m_addr = '0;
        logic         m_we = 1'b0;
        logic [127:0] m_wdata = '0;
        logic [15:0]  m_wmask = '0;
        logic [127:0] m_rdata = '0;
        logic [63:0]  a;
        logic [63:0]  e_ls;
        bit           e_gif, e_gls, e_ifv, e_lsv;
        do_reset();
        rdy_pct  = 70;
        junk_pct = 15;
        for (int c = 0; c < 1500; c++) begin
            a = {$urandom, $urandom};
            a[3:0] = 4'h0;
            if_req_valid = ($urandom_range(99) < 80);
            if_req_addr  = a;
            if_flush     = ($urandom_range(99) < 6);
            ls_req_valid = ($urandom_range(99) < 75);
            ls_req_addr  = {$urandom, $urandom};
            ls_req_we    = $urandom_range(1);
            ls_req_wdata = {$urandom, $urandom};
            ls_req_wmask = 8'($urandom);
            resp_lat     = $urandom_range(1, 3);
            settle();
            e_gif = 1'b0;
            e_gls = 1'b0;
            if (m_phase == 0) begin
                if (if_req_valid && !if_flush && (!ls_req_valid || m_starve == LIMIT)) e_gif = 1'b1;
                else if (ls_req_valid) e_gls = 1'b1;
            end
            n_total++;
            if ({if_req_ready, ls_req_ready} !== {e_gif, e_gls})
                $display("FAIL rnd_ready c%0d got=%b exp=%b", c, {if_req_ready, ls_req_ready}, {e_gif, e_gls});
            else n_pass++;
            n_total++;
            if (mem_req_valid !== (m_phase == 1))
                $display("FAIL rnd_memvalid c%0d got=%b exp=%b", c, mem_req_valid, m_phase == 1);
            else n_pass++;
            if (m_phase == 1) begin
                n_total++;
                if ({mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wmask} !== {m_addr, m_we, m_wdata, m_wmask})
                    $display("FAIL rnd_memreq c%0d got=%h/%b/%h/%h exp=%h/%b/%h/%h", c, mem_req_addr,
                             mem_req_we, mem_req_wdata, mem_req_wmask, m_addr, m_we, m_wdata, m_wmask);
                else n_pass++;
            end
            e_ifv = (m_phase == 3) && !m_ls && !m_drop && !if_flush;
            e_lsv = (m_phase == 3) && m_ls;
            n_total++;
            if ({if_resp_valid, ls_resp_valid} !== {e_ifv, e_lsv})
                $display("FAIL rnd_respvalid c%0d got=%b exp=%b", c, {if_resp_valid, ls_resp_valid}, {e_ifv, e_lsv});
            else n_pass++;
            if (e_ifv) begin
                n_total++;
                if (if_resp_data !== m_rdata) $display("FAIL rnd_ifdata c%0d got=%h exp=%h", c, if_resp_data, m_rdata);
                else n_pass++;
            end
            if (e_lsv) begin
                e_ls = m_we ? 64'h0 : (m_addr[3] ? m_rdata[127:64] : m_rdata[63:0]);
                n_total++;
                if (ls_resp_data !== e_ls) $display("FAIL rnd_lsdata c%0d got=%h exp=%h", c, ls_resp_data, e_ls);
                else n_pass++;
            end
            case (m_phase)
                0: begin
                    if (e_gif) begin
                        m_phase = 1; m_ls = 1'b0; m_addr = if_req_addr;
                        m_we = 1'b0; m_wdata = '0; m_wmask = '0;
                    end else if (e_gls) begin
                        m_phase = 1; m_ls = 1'b1; m_addr = ls_req_addr; m_we = ls_req_we;
                        m_wdata = {ls_req_wdata, ls_req_wdata};
                        m_wmask = ls_req_addr[3] ? {ls_req_wmask, 8'h00} : {8'h00, ls_req_wmask};
                    end
                end
                1: begin
                    if (!m_ls && if_flush) m_drop = 1'b1;
                    if (mem_req_ready) m_phase = 2;
                end
                2: begin
                    if (!m_ls && if_flush) m_drop = 1'b1;
                    if (mem_resp_valid) begin
                        m_phase = 3;
                        m_rdata = mem_resp_data;
                    end
                end
                default: begin
                    m_phase = 0;
                    m_drop  = 1'b0;
                end
            endcase
            if (e_gif || !if_req_valid) m_starve = 0;
            else if (e_gls && m_starve < 7) m_starve++;
            advance();
        end
        junk_pct = 0;
        rdy_pct  = 100;
        drain();
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        test_reset();
        test_if_read();
        test_simultaneous();
        test_starvation();
        test_ls_write();
        test_flush_stall();
        test_reset_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
